lut_neuron_stream: RTL and testbench
====================================

Name: lut_neuron_stream

Overview:
- Parametrised, runtime-programmable successor to the fixed ROM LUT neuron.
- Maps a FAN_IN x IN_BITS input word to an OUT_BITS activation through a 2^(FAN_IN*IN_BITS)-entry table loaded over a config port.
- Sits in the layer datapath with valid/ready streaming on both sides and a 2-stage pipeline.
- Adds backpressure, table commit/invalidate, and a saturating output counter.

Parameters:
- FAN_IN, 4, number of input activations per neuron.
- IN_BITS, 2, bits per input activation.
- OUT_BITS, 2, bits of output activation.
- DEFAULT_OUT, all ones, output value while the table is uncommitted.
- CNT_W, 16, width of the output-beat counter.
- Derived: AW = FAN_IN*IN_BITS, DEPTH = 2^AW.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept an input beat.
- in_data  in  AW  concatenated inputs; input k occupies bits [k*IN_BITS +: IN_BITS].
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- out_data  out  OUT_BITS  activation.
- cfg_wr  in  1  table write strobe.
- cfg_addr  in  AW  table address.
- cfg_wdata  in  OUT_BITS  table entry.
- cfg_commit  in  1  single-cycle pulse; marks the table valid.
- cfg_clear  in  1  single-cycle pulse; marks the table invalid.
- tbl_valid  out  1  table committed.
- out_count  out  CNT_W  accepted output beats, saturating.

Behaviour:
- Reset (async assert, sync deassert handled upstream): s1_valid=0, s2_valid=0, out_valid=0, out_data=0, tbl_valid=0, out_count=0, in_ready=1. Table contents are not reset.
- Stage 1 registers in_data as the address when in_valid && in_ready.
- Stage 2 registers out_data = tbl_valid ? table[s1_addr] : DEFAULT_OUT.
- Latency: an input accepted in cycle N produces out_valid in cycle N+2 with no stall.
- Advance rules:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = s1_valid && s2_adv
  - in_ready = !s1_valid || s2_adv (combinational from out_ready)
  - Full throughput: 1 beat/cycle.
- Handshake: out_data and out_valid stay stable while out_valid && !out_ready. Once asserted, out_valid drops only after a transfer.
- s2_valid clears on transfer when no new s1 beat advances.
- Table write: table[cfg_addr] <= cfg_wdata on cfg_wr, visible from the next cycle.
- Same-cycle cfg_wr and stage-2 lookup of the same address: the lookup returns the old value (read-before-write).
- tbl_valid:
  - Set by cfg_commit, cleared by cfg_clear.
  - Both in the same cycle: clear wins.
  - A lookup in the cycle cfg_commit is asserted uses the pre-commit tbl_valid (DEFAULT_OUT).
  - Beats already in stage 2 are not re-evaluated after commit or clear.
- cfg_wr while tbl_valid=1 is legal; the table is not protected.
- out_count increments on each out_valid && out_ready and holds at 2^CNT_W-1.
- Reset mid-operation: in-flight beats are discarded, out_valid drops immediately, and table contents are retained. Software must re-commit after reset.
- No combinational path from in_valid to out_valid. The only combinational path is out_ready -> in_ready.

Test Plan:
- Default parameters, reset, no load; send in_data=8'hFC with out_ready=1 -> out_valid at cycle+2, out_data=2'b11, tbl_valid=0, out_count=1.
- Write table[a] = a[7:6]^a[1:0] for all 256 addresses, pulse cfg_commit; stream addresses 0..255 back-to-back -> 256 consecutive beats, each out_data matches, in_ready stays 1, out_count=256.
- Stream 8 beats with out_ready held 0 -> in_ready drops after 2 accepted. Release out_ready -> beats emerge in order, none lost or duplicated, out_data stable while stalled.
- Same cycle: cfg_wr addr 8'h3C data 2'b01 and stage-2 lookup of 8'h3C (old value 2'b10) -> out 2'b10. The next lookup of 8'h3C -> 2'b01.
- Assert cfg_commit and cfg_clear together -> tbl_valid=0, subsequent outputs DEFAULT_OUT.
- CNT_W=3; 10 transfers -> out_count saturates at 7. Assert rst_n=0 with 2 beats in flight -> out_valid=0 immediately, count 0, table intact (after commit, lookup of a previously written address is correct).

Source files
------------

// File: rtl/lut_neuron_stream.sv
`default_nettype none
// ============================================================================
// Module   : lut_neuron_stream
// Purpose  : Runtime-programmable LUT neuron. A FAN_IN x IN_BITS input word is
//            used as the address into a 2^(FAN_IN*IN_BITS)-entry table of
//            OUT_BITS activations. The table is loaded over a config port and
//            marked valid/invalid with commit/clear pulses. The datapath is a
//            2-stage valid/ready pipeline with full throughput and
//            backpressure, plus a saturating count of delivered beats.
// Ports    : clk, rst_n             - clock (rising edge), async active-low reset
//            in_valid/in_ready/in_data    - upstream stream (address word)
//            out_valid/out_ready/out_data - downstream stream (activation)
//            cfg_wr/cfg_addr/cfg_wdata    - table write port
//            cfg_commit/cfg_clear         - table valid set/clear pulses
//            tbl_valid              - table committed flag
//            out_count              - accepted output beats, saturating
// Revision : 1.0 - initial release
// ============================================================================
module lut_neuron_stream #(
  parameter int                  FAN_IN      = 4,
  parameter int                  IN_BITS     = 2,
  parameter int                  OUT_BITS    = 2,
  parameter logic [OUT_BITS-1:0] DEFAULT_OUT = '1,
  parameter int                  CNT_W       = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  // upstream stream
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [FAN_IN*IN_BITS-1:0]   in_data,
  // downstream stream
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_BITS-1:0]         out_data,
  // configuration
  input  logic                        cfg_wr,
  input  logic [FAN_IN*IN_BITS-1:0]   cfg_addr,
  input  logic [OUT_BITS-1:0]         cfg_wdata,
  input  logic                        cfg_commit,
  input  logic                        cfg_clear,
  // status
  output logic                        tbl_valid,
  output logic [CNT_W-1:0]            out_count
);

  localparam int               AW      = FAN_IN * IN_BITS;
  localparam int               DEPTH   = 1 << AW;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // --------------------------------------------------------------------------
  // Table storage. Deliberately not reset so that contents survive a reset;
  // software only needs to re-commit.
  // --------------------------------------------------------------------------
  logic [OUT_BITS-1:0] lut_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (cfg_wr) begin
      lut_mem[cfg_addr] <= cfg_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Pipeline control. Stage 2 is the output register itself, so out_valid
  // doubles as the stage-2 valid flag.
  // --------------------------------------------------------------------------
  logic          s1_valid;
  logic [AW-1:0] s1_addr;
  logic          s2_adv;
  logic          s1_adv;
  logic          out_xfer;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_adv;
  // Only combinational path through the block: out_ready -> in_ready.
  assign in_ready = !s1_valid || s2_adv;
  assign out_xfer = out_valid && out_ready;

  // Stage 1: capture the address. When in_ready is high, stage 1 is either
  // empty or handing its beat to stage 2 this cycle, so it may be refilled
  // (or emptied when no new beat arrives).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_addr <= in_data;
      end
    end
  end

  // Stage 2: table lookup into the output register. The memory read sees the
  // pre-write contents when cfg_wr targets the same address this cycle, and
  // tbl_valid is the pre-commit/clear value, so a beat is evaluated against
  // the state that existed before this edge. Once loaded, a beat is frozen
  // until transferred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_adv;
      if (s1_adv) begin
        out_data <= tbl_valid ? lut_mem[s1_addr] : DEFAULT_OUT;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Table valid flag: clear has priority over commit.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_valid <= 1'b0;
    end else if (cfg_clear) begin
      tbl_valid <= 1'b0;
    end else if (cfg_commit) begin
      tbl_valid <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Delivered-beat counter, sticks at all ones.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_count <= '0;
    end else if (out_xfer && (out_count != CNT_MAX)) begin
      out_count <= out_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lut_neuron_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_lut_neuron_stream
// Purpose  : Self-checking bench for lut_neuron_stream. Main instance uses
//            default parameters; a second instance uses CNT_W=3 to exercise
//            counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lut_neuron_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main instance signals
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, cfg_addr;
  logic [1:0] out_data, cfg_wdata;
  logic       cfg_wr, cfg_commit, cfg_clear, tbl_valid;
  logic [15:0] out_count;

  // small-counter instance signals
  logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [7:0] s_in_data, s_cfg_addr;
  logic [1:0] s_out_data, s_cfg_wdata;
  logic       s_cfg_wr, s_cfg_commit, s_cfg_clear, s_tbl_valid;
  logic [2:0] s_out_count;

  lut_neuron_stream dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_commit(cfg_commit), .cfg_clear(cfg_clear),
    .tbl_valid(tbl_valid), .out_count(out_count)
  );

  lut_neuron_stream #(.CNT_W(3)) dut_c3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .cfg_wr(s_cfg_wr), .cfg_addr(s_cfg_addr), .cfg_wdata(s_cfg_wdata),
    .cfg_commit(s_cfg_commit), .cfg_clear(s_cfg_clear),
    .tbl_valid(s_tbl_valid), .out_count(s_out_count)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] addr;
    logic [1:0] exp;
  } vec_t;

  vec_t vecs [10];
  logic [7:0] stall_addr [8];

  function automatic logic [1:0] model(input logic [7:0] a);
    return a[7:6] ^ a[1:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single beat with out_ready=1: accept, wait two edges, check, let it drain.
  task automatic lookup(input string name, input logic [7:0] a, input logic [1:0] exp);
    in_valid = 1'b1;
    in_data  = a;
    tick();
    in_valid = 1'b0;
    chk({name, "_lat1"}, {31'd0, out_valid}, 32'd0);
    tick();
    chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, "_data"}, {30'd0, out_data}, {30'd0, exp});
    tick();
  endtask

  initial begin
    int sent, got;
    logic [1:0] held;
    logic ready_ok;

    vecs[0] = '{8'h00, 2'd0}; vecs[1] = '{8'hFF, 2'd0};
    vecs[2] = '{8'hC1, 2'd2}; vecs[3] = '{8'h41, 2'd0};
    vecs[4] = '{8'h80, 2'd2}; vecs[5] = '{8'h03, 2'd3};
    vecs[6] = '{8'h01, 2'd1}; vecs[7] = '{8'h40, 2'd1};
    vecs[8] = '{8'h96, 2'd0}; vecs[9] = '{8'h7E, 2'd3};
    stall_addr[0] = 8'h01; stall_addr[1] = 8'h02; stall_addr[2] = 8'hC3;
    stall_addr[3] = 8'h40; stall_addr[4] = 8'h81; stall_addr[5] = 8'hFE;
    stall_addr[6] = 8'h7D; stall_addr[7] = 8'hA6;

    in_valid = 0; in_data = 0; out_ready = 1;
    cfg_wr = 0; cfg_addr = 0; cfg_wdata = 0; cfg_commit = 0; cfg_clear = 0;
    s_in_valid = 0; s_in_data = 0; s_out_ready = 1;
    s_cfg_wr = 0; s_cfg_addr = 0; s_cfg_wdata = 0; s_cfg_commit = 0; s_cfg_clear = 0;

    repeat (3) tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {30'd0, out_data}, 32'd0);
    chk("rst_tbl_valid", {31'd0, tbl_valid}, 32'd0);
    chk("rst_out_count", {16'd0, out_count}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // Uncommitted table -> DEFAULT_OUT
    lookup("nocommit_fc", 8'hFC, 2'b11);
    chk("nocommit_tbl_valid", {31'd0, tbl_valid}, 32'd0);
    chk("nocommit_count", {16'd0, out_count}, 32'd1);

    // Saturating counter on the CNT_W=3 instance (table uncommitted)
    for (int i = 0; i < 12; i++) begin
      s_in_valid = (i < 10);
      s_in_data  = i[7:0];
      if (i == 2) begin
        chk("c3_first_valid", {31'd0, s_out_valid}, 32'd1);
        chk("c3_first_data", {30'd0, s_out_data}, 32'd3);
      end
      if (i == 9) chk("c3_count7", {29'd0, s_out_count}, 32'd7);
      tick();
    end
    s_in_valid = 1'b0;
    chk("c3_saturate", {29'd0, s_out_count}, 32'd7);

    // Load full table, reset (contents retained), commit
    for (int a = 0; a < 256; a++) begin
      cfg_wr = 1'b1; cfg_addr = a[7:0]; cfg_wdata = model(a[7:0]);
      tick();
    end
    cfg_wr = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    chk("commit_tbl_valid", {31'd0, tbl_valid}, 32'd1);

    // Back-to-back stream of all 256 addresses
    ready_ok = 1'b1;
    for (int c = 0; c < 258; c++) begin
      in_valid = (c < 256);
      in_data  = c[7:0];
      #1;
      if (c < 256 && in_ready !== 1'b1) ready_ok = 1'b0;
      if (c >= 2) begin
        chk("stream_valid", {31'd0, out_valid}, 32'd1);
        chk("stream_data", {30'd0, out_data}, {30'd0, model(8'(c - 2))});
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("stream_in_ready", {31'd0, ready_ok}, 32'd1);
    chk("stream_count", {16'd0, out_count}, 32'd256);

    // Table-driven single lookups
    foreach (vecs[i]) lookup("vec", vecs[i].addr, vecs[i].exp);

    // Backpressure: 6 cycles stalled, then release
    sent = 0; got = 0; held = 2'b00;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      logic acc_in, acc_out;
      out_ready = (cyc >= 6);
      in_valid  = (sent < 8);
      in_data   = (sent < 8) ? stall_addr[sent] : 8'h00;
      @(negedge clk);
      if (cyc == 5) begin
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        chk("stall_accepted", sent, 2);
      end
      if (cyc >= 2 && cyc < 6) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_data_stable", {30'd0, out_data}, {30'd0, model(stall_addr[0])});
      end
      acc_in  = in_valid && in_ready;
      acc_out = out_valid && out_ready;
      if (acc_out) begin
        chk("stall_order", {30'd0, out_data}, {30'd0, model(stall_addr[got])});
        got++;
      end
      @(posedge clk); #1;
      if (acc_in) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stall_received", got, 8);
    tick();
    chk("stall_drained", {31'd0, out_valid}, 32'd0);

    // Read-before-write on same-cycle cfg_wr and stage-2 lookup
    cfg_wr = 1'b1; cfg_addr = 8'h3C; cfg_wdata = 2'b10;
    tick();
    cfg_wr = 1'b0;
    in_valid = 1'b1; in_data = 8'h3C;
    tick();
    in_valid = 1'b0;
    cfg_wr = 1'b1; cfg_addr = 8'h3C; cfg_wdata = 2'b01;
    tick();
    cfg_wr = 1'b0;
    chk("raw_old_valid", {31'd0, out_valid}, 32'd1);
    chk("raw_old_data", {30'd0, out_data}, 32'd2);
    tick();
    lookup("raw_new", 8'h3C, 2'b01);

    // Lookup in the commit cycle uses the pre-commit flag
    cfg_clear = 1'b1;
    tick();
    cfg_clear = 1'b0;
    chk("clear_tbl_valid", {31'd0, tbl_valid}, 32'd0);
    in_valid = 1'b1; in_data = 8'h41;
    tick();
    in_valid = 1'b0; cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    chk("commit_cycle_data", {30'd0, out_data}, 32'd3);
    chk("commit_cycle_tbl", {31'd0, tbl_valid}, 32'd1);
    tick();
    lookup("post_commit", 8'h41, 2'b00);

    // Commit and clear together: clear wins
    cfg_commit = 1'b1; cfg_clear = 1'b1;
    tick();
    cfg_commit = 1'b0; cfg_clear = 1'b0;
    chk("both_tbl_valid", {31'd0, tbl_valid}, 32'd0);
    lookup("both_default", 8'h41, 2'b11);

    // Reset with two beats in flight
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hC1;
    tick();
    in_data = 8'h80;
    tick();
    in_valid = 1'b0;
    chk("inflight_valid", {31'd0, out_valid}, 32'd1);
    chk("inflight_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_count", {16'd0, out_count}, 32'd0);
    chk("midrst_tbl_valid", {31'd0, tbl_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("postrst_no_beat", {31'd0, out_valid}, 32'd0);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    lookup("retained_c1", 8'hC1, 2'b10);
    lookup("retained_3c", 8'h3C, 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
